// File: rtl/clock_chain_ctrl.sv
// Mode controller and enable scheduler for the BCD timekeeping counter chain.
// Generates the 1 Hz tick, routes tick/carry or user advance pulses, auto-repeat and set timeout.
module clock_chain_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned RPT_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       adv_btn,
  input  logic       sec_inc_nxt,
  input  logic       min_inc_nxt,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);
  localparam int unsigned RptW  = $clog2(RPT_CYC + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetMin = 2'b01,
    StSetHr  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              blink_q, blink_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic              mode_q, adv_q;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [RptW-1:0]   rpt_q, rpt_d;
  logic              rpt_act_q, rpt_act_d;

  logic tick, mode_rise, adv_rise, in_set;
  logic hold_hit, rpt_hit, adv_pulse;

  always_comb begin
    tick      = (pre_q == PreW'(TICK_DIV - 1));
    pre_d     = tick ? '0 : pre_q + PreW'(1);
    mode_rise = mode_btn & ~mode_q;
    adv_rise  = adv_btn & ~adv_q;
    in_set    = (state_q == StSetMin) || (state_q == StSetHr);
    hold_hit  = adv_btn & ~adv_rise & ~rpt_act_q & (hold_q == HoldW'(HOLD_CYC));
    rpt_hit   = adv_btn & ~adv_rise & rpt_act_q & (rpt_q == RptW'(RPT_CYC));
    // Mode press takes priority over an advance in the same cycle.
    adv_pulse = in_set & ~mode_rise & (adv_rise | hold_hit | rpt_hit);
  end

  // Hold counter runs up to HOLD_CYC, then the repeat counter takes over.
  always_comb begin
    hold_d    = hold_q;
    rpt_d     = rpt_q;
    rpt_act_d = rpt_act_q;
    if (!adv_btn) begin
      hold_d    = '0;
      rpt_d     = '0;
      rpt_act_d = 1'b0;
    end else if (adv_rise) begin
      hold_d    = HoldW'(1);
      rpt_d     = '0;
      rpt_act_d = 1'b0;
    end else if (!rpt_act_q) begin
      if (hold_q == HoldW'(HOLD_CYC)) begin
        rpt_act_d = 1'b1;
        rpt_d     = RptW'(1);
      end else begin
        hold_d = hold_q + HoldW'(1);
      end
    end else begin
      rpt_d = (rpt_q == RptW'(RPT_CYC)) ? RptW'(1) : rpt_q + RptW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (mode_rise) begin
      idle_d = '0;
      unique case (state_q)
        StSetMin: state_d = StSetHr;
        StSetHr:  state_d = StRun;
        default:  state_d = StSetMin;
      endcase
    end else if (in_set) begin
      if (adv_btn) begin
        idle_d = '0;
      end else if (tick) begin
        if (idle_q == IdleW'(TIMEOUT - 1)) begin
          state_d = StRun;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
    end else begin
      idle_d = '0;
    end

    if (state_d == StRun) begin
      blink_d = 1'b0;
    end else if (!in_set) begin
      blink_d = 1'b1;
    end else begin
      blink_d = tick ? ~blink_q : blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      blink_q   <= 1'b0;
      idle_q    <= '0;
      pre_q     <= '0;
      mode_q    <= 1'b0;
      adv_q     <= 1'b0;
      hold_q    <= '0;
      rpt_q     <= '0;
      rpt_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      blink_q   <= blink_d;
      idle_q    <= idle_d;
      pre_q     <= pre_d;
      mode_q    <= mode_btn;
      adv_q     <= adv_btn;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      rpt_act_q <= rpt_act_d;
    end
  end

  // Encoding 11 is unreachable but decodes as RUN.
  always_comb begin
    mode  = state_q;
    blink = blink_q;
    unique case (state_q)
      StSetMin: begin
        sec_en  = 1'b0;
        min_en  = adv_pulse;
        hr_en   = 1'b0;
        sec_clr = 1'b1;
      end
      StSetHr: begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hr_en   = adv_pulse;
        sec_clr = 1'b1;
      end
      default: begin
        sec_en  = tick;
        min_en  = sec_inc_nxt;
        hr_en   = min_inc_nxt;
        sec_clr = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_chain_ctrl.sv
// Scoreboard bench for clock_chain_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_clock_chain_ctrl;

  localparam int TD   = 4;
  localparam int HOLD = 8;
  localparam int RPT  = 3;
  localparam int TO   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_btn = 1'b0, adv_btn = 1'b0, sec_inc_nxt = 1'b0, min_inc_nxt = 1'b0;
  logic       sec_en, min_en, hr_en, sec_clr, blink;
  logic [1:0] mode;

  clock_chain_ctrl #(
    .TICK_DIV(TD),
    .HOLD_CYC(HOLD),
    .RPT_CYC (RPT),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_btn   (mode_btn),
    .adv_btn    (adv_btn),
    .sec_inc_nxt(sec_inc_nxt),
    .min_inc_nxt(min_inc_nxt),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .hr_en      (hr_en),
    .sec_clr    (sec_clr),
    .mode       (mode),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sec_en;
    logic       min_en;
    logic       hr_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: cycle position within the second, button history, hold length, mode, idle ticks.
  int pre = 0, held = 0, md = 0, idle = 0;
  bit pm = 0, pa = 0, blk = 0;

  task automatic step(input bit r, input bit m, input bit a, input bit s, input bit mi);
    bit   tick, mrise, arise, pulse, ap;
    int   hl, nm;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; mode_btn = m; adv_btn = a; sec_inc_nxt = s; min_inc_nxt = mi;
    if (!r) begin
      pre = 0; held = 0; md = 0; idle = 0; pm = 0; pa = 0; blk = 0;
    end
    tick  = (pre == TD - 1);
    mrise = m && !pm;
    arise = a && !pa;
    hl    = a ? (arise ? 1 : held + 1) : 0;
    pulse = a && (hl == 1 || (hl - 1 >= HOLD && (hl - 1 - HOLD) % RPT == 0));
    ap    = pulse && md != 0 && !mrise;
    e.mode  = 2'(md);
    e.blink = blk;
    case (md)
      1:       begin e.sec_en = 0;    e.min_en = ap; e.hr_en = 0;  e.sec_clr = 1; end
      2:       begin e.sec_en = 0;    e.min_en = 0;  e.hr_en = ap; e.sec_clr = 1; end
      default: begin e.sec_en = tick; e.min_en = s;  e.hr_en = mi; e.sec_clr = 0; end
    endcase
    exp_q.push_back(e);
    cyc_q.push_back(cycle);
    if (r) begin
      nm = md;
      if (mrise) begin
        nm   = (md + 1) % 3;
        idle = 0;
      end else if (md != 0) begin
        if (a) idle = 0;
        else if (tick) idle++;
        if (idle == TO) begin
          nm   = 0;
          idle = 0;
        end
      end
      if (nm == 0) blk = 0;
      else if (md == 0) blk = 1;
      else if (tick) blk = !blk;
      md   = nm;
      pre  = (pre + 1) % TD;
      pm   = m;
      pa   = a;
      held = hl;
    end
    cycle++;
  endtask

  task automatic press();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e, got;
    int   c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        c   = cyc_q.pop_front();
        got = {sec_en, min_en, hr_en, sec_clr, mode, blink};
        checks++;
        if (got !== e)
          begin
          errors++;
          $display("FAIL outputs cycle %0d: got {sec,min,hr,clr,mode,blink}=%b required %b",
                   c, got, e);
        end
      end
    end
  end

  initial begin : driver
    bit m, a;
    int waited;
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (12) step(1, 0, 0, 0, 0);
    repeat (12) step(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) begin
      press();
      repeat (9) step(1, 0, 0, 0, 0);
    end
    // SET_MIN with a long hold to exercise auto-repeat.
    press();
    repeat (15) step(1, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1, 0, 0, 0, 0);
    press();
    repeat (30) step(1, 0, 0, 0, 0);
    // Simultaneous mode and advance rises from SET_MIN.
    press();
    step(1, 1, 1, 0, 0);
    repeat (12) step(1, 1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    // Reset in the middle of a hold.
    press(); press(); press();
    repeat (10) step(1, 0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    repeat (14) step(1, 0, 1, 0, 0);
    m = 0; a = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) m = !m;
      if ($urandom_range(0, 24) == 0) a = !a;
      step(1, m, a, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
